mul_unit_seq: RTL and testbench

// Sequential 32x32 multiplier serving the MUL slots of the execution unit
// (ex_op 2'b10 unsigned, 2'b11 signed), which today return 0.

---
 rtl/mul_unit_seq.sv | 130 +++++++++++++
 tb/tb_mul_unit_seq.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mul_unit_seq.sv
// Sequential radix-2 shift-add multiplier (unsigned/signed) with a start/busy/done handshake.
// Accept -> WIDTH CALC cycles -> one FIX cycle -> DONE pulse; new starts are taken only in IDLE or DONE.
module mul_unit_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       ex_op,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state_q,  state_d;
  logic [2*WIDTH-1:0]   mcand_q,  mcand_d;
  logic [2*WIDTH-1:0]   acc_q,    acc_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]        count_q,  count_d;
  logic                 sign_q,   sign_d;
  logic [WIDTH-1:0]     res_lo_q, res_lo_d;
  logic [WIDTH-1:0]     res_hi_q, res_hi_d;
  logic                 zero_q,   zero_d;

  logic                 accept;
  logic                 neg_a, neg_b;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [2*WIDTH-1:0]   prod_fix;
  logic                 last_step;

  assign accept = ((state_q == IDLE) || (state_q == DONE)) && start && ex_op[1];

  // Magnitude of the most negative value wraps to 2^(WIDTH-1), still exact as unsigned.
  assign neg_a = ex_op[0] & A[WIDTH-1];
  assign neg_b = ex_op[0] & B[WIDTH-1];
  assign mag_a = neg_a ? -A : A;
  assign mag_b = neg_b ? -B : B;

  assign last_step = (count_q == CW'(WIDTH - 1));
  assign prod_fix  = sign_q ? -acc_q : acc_q;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    sign_d   = sign_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    zero_d   = zero_q;

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          mcand_d  = {{WIDTH{1'b0}}, mag_a};
          mplier_d = mag_b;
          acc_d    = '0;
          count_d  = '0;
          sign_d   = ex_op[0] & (A[WIDTH-1] ^ B[WIDTH-1]);
          state_d  = CALC;
        end else begin
          state_d  = IDLE;
        end
      end
      CALC: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CW'(1);
        if (last_step) begin
          state_d = FIX;
        end
      end
      FIX: begin
        res_lo_d = prod_fix[WIDTH-1:0];
        res_hi_d = prod_fix[2*WIDTH-1:WIDTH];
        zero_d   = (prod_fix == '0);
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      sign_q   <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      sign_q   <= sign_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      zero_q   <= zero_d;
    end
  end

  assign busy      = (state_q == CALC) || (state_q == FIX);
  assign done      = (state_q == DONE);
  assign result    = res_lo_q;
  assign result_hi = res_hi_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_mul_unit_seq.sv
// Directed bench for mul_unit_seq: products, latency, ignored starts, back-to-back issue and mid-op reset.
module tb_mul_unit_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] A, B;
  logic [1:0]  ex_op;
  logic        start;
  logic        busy, done, zero;
  logic [31:0] result, result_hi;

  int total = 0;
  int bad   = 0;

  mul_unit_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .ex_op     (ex_op),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .result_hi (result_hi),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Drive a request now, return edges from accept until done is seen (bounded).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        output int lat, output logic busy0);
    A = a; B = b; ex_op = op; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy0 = busy;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic mul_chk(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic [63:0] exp);
    int   lat;
    logic b0;
    run_op(a, b, op, lat, b0);
    chk({tag, "_lat"}, 64'(lat), 64'd33);
    chk({tag, "_lo"},  {32'd0, result},    {32'd0, exp[31:0]});
    chk({tag, "_hi"},  {32'd0, result_hi}, {32'd0, exp[63:32]});
    chk({tag, "_z"},   {63'd0, zero},      {63'd0, (exp == 64'd0)});
  endtask

  initial begin
    int   lat;
    logic b0;
    logic seen;
    A = '0; B = '0; ex_op = 2'b00; start = 1'b0;

    #12;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_lo",   {32'd0, result}, 64'd0);
    chk("rst_hi",   {32'd0, result_hi}, 64'd0);
    chk("rst_zero", {63'd0, zero}, 64'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    mul_chk("u7x6", 32'd7, 32'd6, 2'b10, 64'd42);
    @(posedge clk); #1;
    chk("hold_done", {63'd0, done}, 64'd0);
    chk("hold_lo",   {32'd0, result}, 64'd42);

    mul_chk("u_ffxff",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 64'hFFFF_FFFE_0000_0001);
    mul_chk("s_m3x5",    32'hFFFF_FFFD, 32'd5,         2'b11, 64'hFFFF_FFFF_FFFF_FFF1);
    mul_chk("u_fdx5",    32'hFFFF_FFFD, 32'd5,         2'b10, 64'h0000_0004_FFFF_FFF1);
    mul_chk("s_m1xm1",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 64'd1);
    mul_chk("s_7xm6",    32'd7,         32'hFFFF_FFFA, 2'b11, 64'hFFFF_FFFF_FFFF_FFD6);
    mul_chk("s_minxmin", 32'h8000_0000, 32'h8000_0000, 2'b11, 64'h4000_0000_0000_0000);
    mul_chk("s_0xm9",    32'd0,         32'hFFFF_FFF7, 2'b11, 64'd0);

    // Non-MUL ops must not start
    @(posedge clk); #1;
    A = 32'd3; B = 32'd3; ex_op = 2'b01; start = 1'b1;
    @(posedge clk); #1;
    chk("op01_busy", {63'd0, busy}, 64'd0);
    ex_op = 2'b00;
    @(posedge clk); #1;
    chk("op00_busy", {63'd0, busy}, 64'd0);
    start = 1'b0;
    chk("op_ign_z", {63'd0, zero}, 64'd1);

    // Back-to-back: second request issued in the DONE cycle
    mul_chk("b2b_a", 32'd11, 32'd3, 2'b10, 64'd33);
    run_op(32'd9, 32'd9, 2'b10, lat, b0);
    chk("b2b_busy", {63'd0, b0}, 64'd1);
    chk("b2b_lat",  64'(lat), 64'd33);
    chk("b2b_lo",   {32'd0, result}, 64'd81);

    // Start with new operands mid-CALC is ignored
    @(posedge clk); #1;
    A = 32'd7; B = 32'd6; ex_op = 2'b10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    A = 32'd100; B = 32'd3; ex_op = 2'b11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("mid_lat", 64'(lat), 64'd27);
    chk("mid_lo",  {32'd0, result}, 64'd42);
    chk("mid_hi",  {32'd0, result_hi}, 64'd0);

    // Reset at CALC count=10 aborts without a done pulse
    @(posedge clk); #1;
    A = 32'd7; B = 32'd6; ex_op = 2'b10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_done", {63'd0, done}, 64'd0);
    chk("arst_lo",   {32'd0, result}, 64'd0);
    chk("arst_hi",   {32'd0, result_hi}, 64'd0);
    chk("arst_zero", {63'd0, zero}, 64'd1);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("arst_nodone", {63'd0, seen}, 64'd0);
    mul_chk("post_5x5", 32'd5, 32'd5, 2'b10, 64'd25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
